// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch front end: a fetch PC walks a word-addressed instruction
//   memory and pushes {pc, instr, fault} entries into a small prefetch FIFO.
//   Decode pops the FIFO with a valid/ready handshake. A redirect flushes the
//   FIFO and restarts fetch at the target. A misaligned or out-of-range fetch
//   enqueues a NOP-coded fault entry and stops fetching until the next redirect.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset_n        asynchronous active-low reset
//   imem_we        instruction memory write enable (program load)
//   imem_waddr     instruction memory word address for the write
//   imem_wdata     instruction memory write data
//   redirect_valid redirect request (flush + new fetch PC)
//   redirect_pc    redirect target byte address
//   out_valid      head FIFO entry valid
//   out_ready      decode accepts the head entry
//   out_instr      head entry instruction (0 when out_valid=0)
//   out_pc         head entry byte address (0 when out_valid=0)
//   out_fault      head entry is a fetch fault (0 when out_valid=0)
//
// State  | meaning
// -------+-------------------------------------------------
// RUN    | fetching one word per cycle while FIFO has room
// HALT   | fault entry issued, fetch stopped until redirect

module fetch_unit #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr,
    output logic [31:0]                   out_pc,
    output logic                          out_fault
);

    localparam int          AW        = $clog2(IMEM_DEPTH);
    localparam int          PW        = $clog2(BUF_DEPTH);
    localparam logic [31:0] FAULT_NOP = 32'h0000_0013;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;

    logic [31:0]   mem       [IMEM_DEPTH];
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic          buf_fault [BUF_DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;

    logic          full;
    logic          pop;
    logic          push;
    logic          fetch_fault;
    logic [31:0]   mem_rdata;
    logic [31:0]   push_instr;
    logic          push_fault;

    assign full      = (count == (PW+1)'(BUF_DEPTH));
    assign out_valid = (count != '0);

    // A redirect completes any concurrent handshake by flushing, so it is not
    // treated as a separate pop.
    assign pop = out_valid && out_ready && !redirect_valid;

    assign fetch_fault = (fpc_q[1:0] != 2'b00) || (fpc_q[31:AW+2] != '0);
    assign mem_rdata   = mem[fpc_q[AW+1:2]];

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        push       = 1'b0;
        push_instr = mem_rdata;
        push_fault = 1'b0;
        if (redirect_valid) begin
            state_d = ST_RUN;
            fpc_d   = redirect_pc;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!full || pop) begin
                        push = 1'b1;
                        if (fetch_fault) begin
                            push_instr = FAULT_NOP;
                            push_fault = 1'b1;
                            state_d    = ST_HALT;
                        end else begin
                            fpc_d = fpc_q + 32'd4;
                        end
                    end
                end
                ST_HALT: begin
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            fpc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO payload needs no reset: out_valid masks it whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= fpc_q;
            buf_instr[wr_ptr] <= push_instr;
            buf_fault[wr_ptr] <= push_fault;
        end
    end

    // Memory survives reset; the fetch read above sees the pre-edge contents.
    always_ff @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
    end

    assign out_pc    = out_valid ? buf_pc[rd_ptr]    : 32'h0;
    assign out_instr = out_valid ? buf_instr[rd_ptr] : 32'h0;
    assign out_fault = out_valid ? buf_fault[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int DEPTH = 256;
    localparam int BDEP  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .BUF_DEPTH(BDEP)) dut (
        .clk(clk), .reset_n(reset_n), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] fpc_m = 32'h0;
    bit          halted = 0;

    task automatic model_reset();
        q.delete();
        fpc_m  = 32'h0;
        halted = 0;
    endtask

    always @(negedge reset_n) model_reset();

    always @(posedge clk) begin
        bit   do_pop, do_push;
        ent_t e;
        if (!reset_n) begin
            model_reset();
        end else if (redirect_valid) begin
            q.delete();
            fpc_m  = redirect_pc;
            halted = 0;
        end else begin
            do_pop  = (q.size() != 0) && out_ready;
            do_push = !halted && ((q.size() < BDEP) || do_pop);
            if (do_push) begin
                e.pc = fpc_m;
                if ((fpc_m % 4 != 0) || (fpc_m / 4 >= DEPTH)) begin
                    e.instr = 32'h13;
                    e.fault = 1'b1;
                    halted  = 1;
                end else begin
                    e.instr = mem_m[fpc_m[9:2]];
                    e.fault = 1'b0;
                    fpc_m   = fpc_m + 32'd4;
                end
            end
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        if (imem_we) mem_m[imem_waddr] = imem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model head.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            check("cmp_valid", {31'b0, out_valid}, 32'd1);
            check("cmp_pc",    out_pc,    q[0].pc);
            check("cmp_instr", out_instr, q[0].instr);
            check("cmp_fault", {31'b0, out_fault}, {31'b0, q[0].fault});
        end else begin
            check("cmp_valid", {31'b0, out_valid}, 32'd0);
            check("cmp_pc0",   out_pc,    32'h0);
            check("cmp_instr0", out_instr, 32'h0);
            check("cmp_fault0", {31'b0, out_fault}, 32'd0);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'h0);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] prog [5];
        prog = '{32'h00000013, 32'h00108093, 32'h00210113, 32'h00318193, 32'h00420213};
        if (i < 5) return prog[i];
        return 32'hA000_0000 | 32'(i);
    endfunction

    initial begin
        logic [31:0] exp_i [5];
        exp_i = '{32'h00000013, 32'h00108093, 32'h00210113, 32'h00318193, 32'h00420213};

        #1;
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_instr", out_instr, 32'h0);

        // program load while held in reset
        for (int i = 0; i < DEPTH; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 8'(i);
            imem_wdata = init_word(i);
            tick();
        end
        imem_we = 1'b0;

        // consecutive fetch with decode always ready
        reset_n   = 1'b1;
        out_ready = 1'b1;
        check("rel_valid0", {31'b0, out_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("seq_valid", {31'b0, out_valid}, 32'd1);
            check("seq_pc", out_pc, 32'(k * 4));
            check("seq_instr", out_instr, exp_i[k]);
            check("seq_fault", {31'b0, out_fault}, 32'd0);
        end

        // backpressure: head holds at pc 0, then drains with nothing lost
        reset_pulse();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_pc", out_pc, 32'h0);
            check("bp_hold_instr", out_instr, 32'h13);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("bp_drain_pc", out_pc, 32'(k * 4));
        end

        // redirect while buffer holds pc 8,12
        reset_pulse();
        out_ready = 1'b1;
        tick(); tick(); tick();
        out_ready = 1'b0;
        tick();
        check("rd_head8", out_pc, 32'h8);
        redirect(32'h40);
        check("rd_bubble", {31'b0, out_valid}, 32'd0);
        tick();
        check("rd_tgt_pc", out_pc, 32'h40);
        check("rd_tgt_instr", out_instr, 32'hA000_0010);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("rd_after_pc", out_pc, 32'h40 + 32'(k * 4));
        end

        // faults: misaligned, out of range, and the last valid word
        for (int f = 0; f < 2; f++) begin
            out_ready = 1'b0;
            redirect(f == 0 ? 32'h102 : 32'h400);
            check("flt_bubble", {31'b0, out_valid}, 32'd0);
            tick();
            check("flt_pc", out_pc, f == 0 ? 32'h102 : 32'h400);
            check("flt_instr", out_instr, 32'h13);
            check("flt_fault", {31'b0, out_fault}, 32'd1);
            tick();
            check("flt_hold", out_pc, f == 0 ? 32'h102 : 32'h400);
            out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                tick();
                check("flt_halt", {31'b0, out_valid}, 32'd0);
            end
        end
        out_ready = 1'b0;
        redirect(32'h3FC);
        tick();
        check("top_pc", out_pc, 32'h3FC);
        check("top_instr", out_instr, 32'hA000_00FF);
        tick();
        out_ready = 1'b1;
        tick();
        check("top_flt_pc", out_pc, 32'h400);
        check("top_flt", {31'b0, out_fault}, 32'd1);
        tick();
        check("top_halt", {31'b0, out_valid}, 32'd0);

        // redirect coincident with a handshake on a full buffer
        out_ready = 1'b0;
        redirect(32'h0);
        tick(); tick();
        check("full_head", out_pc, 32'h0);
        out_ready = 1'b1;
        redirect(32'h20);
        out_ready = 1'b0;
        check("hs_rd_empty", {31'b0, out_valid}, 32'd0);
        tick();
        check("hs_rd_pc", out_pc, 32'h20);
        check("hs_rd_instr", out_instr, 32'hA000_0008);

        // asynchronous reset between edges
        out_ready = 1'b1;
        tick(); tick(); tick();
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_pc", out_pc, 32'h0);
        check("arst_instr", out_instr, 32'h0);
        check("arst_fault", {31'b0, out_fault}, 32'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        check("arst_re_pc0", out_pc, 32'h0);
        check("arst_re_i0", out_instr, 32'h13);
        tick();
        check("arst_re_pc4", out_pc, 32'h4);
        check("arst_re_i4", out_instr, 32'h00108093);

        // randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            int r;
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 9);
            if (r < 7)       redirect_pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            else if (r == 7) redirect_pc = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else if (r == 8) redirect_pc = 32'($urandom_range(256, 1023)) << 2;
            else             redirect_pc = ($urandom_range(0, 1) != 0) ? 32'h3F8 : 32'h3FC;
            imem_we    = ($urandom_range(0, 3) == 0);
            imem_waddr = 8'($urandom_range(0, 255));
            imem_wdata = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        imem_we        = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
